// File: rtl/l0_cache_maint_ctrl.sv
// Valid-RAM maintenance sequencer for the L0 data cache: post-reset sweep,
// full invalidation and index-range invalidation through the override clear port.
module l0_cache_maint_ctrl #(
  parameter int CACHE_DEPTH         = 128,
  parameter int XLEN                = 32,
  parameter int MEM_BYTE_ADDR_WIDTH = 16,
  localparam int IW                 = $clog2(CACHE_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush_all_req,
  input  logic            i_inv_req,
  input  logic [XLEN-1:0] i_inv_base_addr,
  input  logic [IW:0]     i_inv_num_words,
  input  logic            i_pipe_cache_write_en,
  output logic            o_req_ready,
  output logic            o_ack,
  output logic            o_done,
  output logic            o_busy,
  output logic            o_stall_pipeline,
  output logic            o_valid_clear_en,
  output logic [IW-1:0]   o_valid_clear_index,
  output logic            o_err
);

  typedef enum logic [1:0] {
    ST_RST_CLR = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CLR     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [IW:0]   DEPTH_CNT  = (IW+1)'(CACHE_DEPTH);
  localparam logic [IW-1:0] LAST_INDEX = IW'(CACHE_DEPTH - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cursor_q, cursor_d;
  logic [IW:0]   remain_q, remain_d;
  logic          first_q, first_d;
  logic          err_q, err_d;

  logic [IW-1:0] req_start;
  logic [IW:0]   req_count;
  logic          req_valid;

  // Only the index bits of the base address matter; tag bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_inv_base_addr;

  assign req_valid = i_flush_all_req | i_inv_req;
  assign req_start = i_flush_all_req ? '0 : i_inv_base_addr[2 +: IW];
  assign req_count = i_flush_all_req ? DEPTH_CNT :
                     ((i_inv_num_words > DEPTH_CNT) ? DEPTH_CNT : i_inv_num_words);

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    remain_d = remain_q;
    first_d  = 1'b0;
    err_d    = err_q;

    case (state_q)
      ST_RST_CLR: begin
        cursor_d = cursor_q + IW'(1);
        if (cursor_q == LAST_INDEX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid && !i_pipe_cache_write_en) begin
          first_d  = 1'b1;
          cursor_d = req_start;
          remain_d = req_count;
          state_d  = (req_count == '0) ? ST_DONE : ST_CLR;
        end
      end
      ST_CLR: begin
        cursor_d = cursor_q + IW'(1);
        remain_d = remain_q - (IW+1)'(1);
        if (remain_q == (IW+1)'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The first clear cycle tolerates a pipeline write already in flight.
    if ((state_q == ST_RST_CLR || state_q == ST_CLR) && i_pipe_cache_write_en && !first_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RST_CLR;
      cursor_q <= '0;
      remain_q <= '0;
      first_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      remain_q <= remain_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  assign o_req_ready         = (state_q == ST_IDLE);
  assign o_busy              = (state_q != ST_IDLE);
  assign o_stall_pipeline    = (state_q != ST_IDLE);
  assign o_valid_clear_en    = (state_q == ST_RST_CLR) || (state_q == ST_CLR);
  assign o_valid_clear_index = cursor_q;
  assign o_done              = (state_q == ST_DONE);
  // first_q also marks the reset sweep's first cycle, which must not ack.
  assign o_ack               = first_q && (state_q != ST_RST_CLR);
  assign o_err               = err_q;

endmodule

// File: tb/tb_l0_cache_maint_ctrl.sv
// Randomized bench for l0_cache_maint_ctrl: a queue of expected per-cycle
// outputs is built from the request rules and compared every cycle.
module tb_l0_cache_maint_ctrl;

  localparam int DEPTH = 128;
  localparam int IW    = $clog2(DEPTH);
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_req;
  logic            inv_req;
  logic [XLEN-1:0] inv_addr;
  logic [IW:0]     inv_num;
  logic            pipe_we;

  logic            o_req_ready, o_ack, o_done, o_busy, o_stall_pipeline;
  logic            o_valid_clear_en, o_err;
  logic [IW-1:0]   o_valid_clear_index;

  always #5 clk = ~clk;

  l0_cache_maint_ctrl #(
    .CACHE_DEPTH(DEPTH),
    .XLEN(XLEN),
    .MEM_BYTE_ADDR_WIDTH(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_flush_all_req(flush_req),
    .i_inv_req(inv_req),
    .i_inv_base_addr(inv_addr),
    .i_inv_num_words(inv_num),
    .i_pipe_cache_write_en(pipe_we),
    .o_req_ready(o_req_ready),
    .o_ack(o_ack),
    .o_done(o_done),
    .o_busy(o_busy),
    .o_stall_pipeline(o_stall_pipeline),
    .o_valid_clear_en(o_valid_clear_en),
    .o_valid_clear_index(o_valid_clear_index),
    .o_err(o_err)
  );

  typedef struct {
    bit ready;
    bit ack;
    bit done;
    bit stall;
    bit clr;
    bit first;
    bit kind_flush;
    int idx;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  bit   chk_en = 1'b0;
  bit   m_err  = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r = '{default: 0};
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic rec_t busy_rec();
    rec_t r = '{default: 0};
    r.stall = 1'b1;
    return r;
  endfunction

  // Reference model: one step per cycle, using this cycle's inputs.
  task automatic model_step();
    rec_t r;
    int   start, n;
    if (rst) begin
      q.delete();
      for (int k = 0; k < DEPTH; k++) begin
        r = busy_rec();
        r.clr = 1'b1;
        r.idx = k;
        r.first = (k == 0);
        q.push_back(r);
      end
      m_err  = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (cur.clr && pipe_we && !cur.first) m_err = 1'b1;
      if (cur.ready && !pipe_we && (flush_req || inv_req)) begin
        if (flush_req) begin
          start = 0;
          n = DEPTH;
        end else begin
          start = int'(inv_addr >> 2) % DEPTH;
          n = (int'(inv_num) > DEPTH) ? DEPTH : int'(inv_num);
        end
        if (n == 0) begin
          r = busy_rec();
          r.ack = 1'b1;
          r.done = 1'b1;
          r.kind_flush = flush_req;
          q.push_back(r);
        end else begin
          for (int k = 0; k < n; k++) begin
            r = busy_rec();
            r.clr = 1'b1;
            r.idx = (start + k) % DEPTH;
            r.ack = (k == 0);
            r.first = (k == 0);
            r.kind_flush = flush_req;
            q.push_back(r);
          end
          r = busy_rec();
          r.done = 1'b1;
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_en) begin
      check_eq("outs", 32'({o_req_ready, o_busy, o_ack, o_done, o_stall_pipeline, o_valid_clear_en}),
               32'({cur.ready, !cur.ready, cur.ack, cur.done, cur.stall, cur.clr}));
      if (cur.clr) check_eq("index", 32'(o_valid_clear_index), 32'(cur.idx));
      check_eq("err", 32'(o_err), 32'(m_err));
    end
    model_step();
    @(posedge clk);
    #1;
    // Requester releases its level request after seeing the ack.
    if (cur.ack) begin
      if (cur.kind_flush) flush_req = 1'b0;
      else inv_req = 1'b0;
    end
    cur = (q.size() != 0) ? q.pop_front() : idle_rec();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_reqs_clear(input string tag);
    for (int k = 0; k < 600 && (flush_req || inv_req); k++) cycle();
    check_eq(tag, 32'({flush_req, inv_req}), 32'd0);
  endtask

  task automatic wait_ack_cycle(input string tag);
    for (int k = 0; k < 300 && !cur.ack; k++) cycle();
    check_eq(tag, 32'(cur.ack), 32'd1);
  endtask

  initial begin
    cur = idle_rec();
    rst = 1'b1;
    flush_req = 1'b0;
    inv_req = 1'b0;
    inv_addr = '0;
    inv_num = '0;
    pipe_we = 1'b0;
    @(posedge clk);
    #1;
    run(3);
    rst = 1'b0;
    run(DEPTH + 4);

    // Range wrapping past the top index
    inv_addr = 32'h0000_01F8;
    inv_num = 8'd3;
    inv_req = 1'b1;
    wait_reqs_clear("wait_range3");
    run(6);

    // Zero-length range, then an over-long range that clamps
    inv_num = 8'd0;
    inv_req = 1'b1;
    wait_reqs_clear("wait_range0");
    run(3);
    inv_addr = 32'h8000_0040;
    inv_num = 8'd200;
    inv_req = 1'b1;
    wait_reqs_clear("wait_range200");
    run(4);

    // Both requests together
    inv_addr = 32'h0000_0010;
    inv_num = 8'd5;
    flush_req = 1'b1;
    inv_req = 1'b1;
    wait_reqs_clear("wait_both");
    run(8);

    // Pipeline write holds off acceptance
    pipe_we = 1'b1;
    inv_addr = 32'h0000_0100;
    inv_num = 8'd4;
    inv_req = 1'b1;
    run(5);
    pipe_we = 1'b0;
    wait_reqs_clear("wait_blocked");
    run(8);

    // Pipeline write in the third clear cycle
    flush_req = 1'b1;
    wait_ack_cycle("wait_ack_err");
    run(2);
    pipe_we = 1'b1;
    run(1);
    pipe_we = 1'b0;
    run(DEPTH + 4);

    // Reset in the middle of a clear sweep, with a request still held
    inv_addr = 32'h0000_0020;
    inv_num = 8'd40;
    inv_req = 1'b1;
    wait_ack_cycle("wait_ack_rst");
    run(6);
    inv_req = 1'b1;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    wait_reqs_clear("wait_after_rst");
    run(50);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      pipe_we = ($urandom_range(0, 9) == 0);
      if (!flush_req && $urandom_range(0, 199) == 0) flush_req = 1'b1;
      if (!inv_req && $urandom_range(0, 29) == 0) inv_req = 1'b1;
      if (inv_req) begin
        inv_addr = $urandom;
        inv_num = ($urandom_range(0, 3) == 0) ? (IW+1)'($urandom_range(0, 255))
                                               : (IW+1)'($urandom_range(0, 9));
      end
      cycle();
    end
    rst = 1'b0;
    pipe_we = 1'b0;
    wait_reqs_clear("wait_final");
    run(DEPTH + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
